// File: rtl/mac_csa_pipe.sv
// Pipelined unsigned multiply-accumulate: 3:2 counter tree per product, carry-save
// accumulation across a group, and a single carry-propagate add at group end.
module mac_csa_pipe #(
  parameter int unsigned W = 12,
  parameter int unsigned E = 4,
  localparam int unsigned AW = 2*W + E
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  output logic          out_ovf
);

  localparam int unsigned PW = 2*W;
  localparam int unsigned CW = E + 2;
  localparam int unsigned NV = 3*W;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << E) + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(1 << E);

  // S1 input register
  logic          r_v1, r_first1, r_last1;
  logic [W-1:0]  r_a1, r_b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_a1     <= '0;
      r_b1     <= '0;
    end else begin
      r_v1     <= in_valid;
      r_first1 <= in_first;
      r_last1  <= in_last;
      r_a1     <= in_a;
      r_b1     <= in_b;
    end
  end

  // S2 partial products reduced level by level with vector 3:2 counters (Wallace style)
  logic [PW-1:0] w_s2, w_c2;

  always_comb begin : p_tree
    logic [PW-1:0] vec [NV];
    logic [PW-1:0] nxt [NV];
    int n;
    for (int k = 0; k < int'(NV); k++) begin
      vec[k] = '0;
      nxt[k] = '0;
    end
    for (int i = 0; i < int'(W); i++) begin
      vec[i] = PW'(r_a1 & {W{r_b1[i]}}) << i;
    end
    n = int'(W);
    for (int l = 0; l < int'(W); l++) begin
      if (n > 2) begin
        for (int k = 0; k < int'(NV); k++) begin
          nxt[k] = '0;
        end
        for (int g = 0; g < int'(W); g++) begin
          if (g < n / 3) begin
            nxt[2*g]   = vec[3*g] ^ vec[3*g+1] ^ vec[3*g+2];
            nxt[2*g+1] = ((vec[3*g] & vec[3*g+1]) | (vec[3*g] & vec[3*g+2]) |
                          (vec[3*g+1] & vec[3*g+2])) << 1;
          end
        end
        for (int r = 0; r < 2; r++) begin
          if (r < n % 3) begin
            nxt[2*(n/3)+r] = vec[3*(n/3)+r];
          end
        end
        n = 2*(n/3) + n%3;
        for (int k = 0; k < int'(NV); k++) begin
          vec[k] = nxt[k];
        end
      end
    end
    w_s2 = vec[0];
    w_c2 = vec[1];
  end

  logic          r_v2, r_first2, r_last2;
  logic [PW-1:0] r_s2, r_c2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_last2  <= 1'b0;
      r_s2     <= '0;
      r_c2     <= '0;
    end else begin
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_s2     <= w_s2;
      r_c2     <= w_c2;
    end
  end

  // S3 carry-save accumulate: two stacked 3:2 levels form the 4:2 compressor
  logic [AW-1:0] r_acc_s, r_acc_c;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_es, w_ec, w_ts, w_tc, w_ns, w_nc;
  logic [AW-1:0] w_acc_s_nx, w_acc_c_nx;
  logic [CW-1:0] w_cnt_nx;

  always_comb begin
    w_es = AW'(r_s2);
    w_ec = AW'(r_c2);
    w_ts = r_acc_s ^ r_acc_c ^ w_es;
    w_tc = ((r_acc_s & r_acc_c) | (r_acc_s & w_es) | (r_acc_c & w_es)) << 1;
    w_ns = w_ts ^ w_tc ^ w_ec;
    w_nc = ((w_ts & w_tc) | (w_ts & w_ec) | (w_tc & w_ec)) << 1;
    if (r_first2) begin
      w_acc_s_nx = w_es;
      w_acc_c_nx = w_ec;
      w_cnt_nx   = CW'(1);
    end else begin
      w_acc_s_nx = w_ns;
      w_acc_c_nx = w_nc;
      w_cnt_nx   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    end
  end

  logic          r_v3;
  logic [AW-1:0] r_snap_s, r_snap_c;
  logic [CW-1:0] r_snap_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_s    <= '0;
      r_acc_c    <= '0;
      r_cnt      <= '0;
      r_v3       <= 1'b0;
      r_snap_s   <= '0;
      r_snap_c   <= '0;
      r_snap_cnt <= '0;
    end else begin
      r_v3 <= 1'b0;
      if (r_v2) begin
        if (r_last2) begin
          // Hand the group to S4 and restart from zero for a possible implicit start
          r_snap_s   <= w_acc_s_nx;
          r_snap_c   <= w_acc_c_nx;
          r_snap_cnt <= w_cnt_nx;
          r_v3       <= 1'b1;
          r_acc_s    <= '0;
          r_acc_c    <= '0;
          r_cnt      <= '0;
        end else begin
          r_acc_s <= w_acc_s_nx;
          r_acc_c <= w_acc_c_nx;
          r_cnt   <= w_cnt_nx;
        end
      end
    end
  end

  // S4 the only carry-propagate add in the unit
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= r_v3;
      if (r_v3) begin
        out_data <= r_snap_s + r_snap_c;
        out_ovf  <= (r_snap_cnt > CNT_LIM);
      end
    end
  end

endmodule
